divider_top: RTL and testbench
==============================

// Module: divider_top
// PURPOSE
//  Histogram-equalisation scaling stage. Walks a CDF table held in scratch memory four
//  32-bit bins per 128-bit word, computes out = floor((A-cdf_min)*255/(B-cdf_min)) per lane
//  (saturated to 255), and writes the equalised 8-bit levels back to scratch memory.
//  Sits between the CDF accumulator and the pixel remap stage, sequenced by the top controller.
// PARAMETERS
//  NUM_WORDS  64       words processed per run (256 bins / 4 lanes)
//  RD1_BASE   16'h0000 base address of numerator CDF words (port 1)
//  RD2_BASE   16'h0040 base address of denominator words (port 2)
//  WT_BASE    16'h0080 base address of result words
// PORTS
//  clk                  in   1    clock, all state on rising edge
//  reset                in   1    asynchronous, active-low reset (0 = reset)
//  enable               in   1    level start request from controller
//  cdf_min              in   32   minimum nonzero CDF value, stable for the whole run
//  div_sc_mem_rd_data1  in   128  numerator word, 4 lanes A[i]=bits[32i+31:32i]
//  div_sc_mem_rd_data2  in   128  denominator word, 4 lanes B[i]
//  div_sc_mem_wt_data   out  128  result word, lane i = {24'b0, q[i][7:0]}
//  div_sc_mem_rd_addr1  out  16   read address port 1 = RD1_BASE + k
//  div_sc_mem_rd_addr2  out  16   read address port 2 = RD2_BASE + k
//  div_sc_mem_wt_addr   out  16   write address = WT_BASE + k
//  div_sc_mem_wt_en     out  1    one-cycle write strobe
//  div_sc_mem_rd_done   out  1    all NUM_WORDS reads captured (held)
//  div_sc_mem_wt_done   out  1    all NUM_WORDS results written (held)
// BEHAVIOUR
//  - Reset: all outputs 0, word index k=0, state IDLE. Reset mid-run aborts immediately.
//  - Memory is synchronous: read data valid the cycle after the address is driven.
//  - FSM: IDLE -> READ -> LOAD -> DIV(8 cycles) -> WRITE -> (READ if k<NUM_WORDS-1 else DONE).
//    IDLE: leave when enable=1. READ: drive rd_addr1/2 for word k.
//    LOAD: capture both words; per lane N=(A-cdf_min)*255 (40-bit), D=B-cdf_min (32-bit).
//    DIV: 8-iteration restoring division producing 8-bit quotient, MSB first.
//    WRITE: wt_en=1 for exactly one cycle with wt_addr/wt_data of word k; k increments.
//  - Per-word latency 11 cycles; full run 11*NUM_WORDS cycles from enable to wt_done.
//  - Lane rules (evaluated in LOAD): A<=cdf_min -> q=0; B<=cdf_min (D=0) -> q=0;
//    N >= 256*D -> q=255 (saturate, skip quotient). All four lanes run in parallel.
//  - rd_done rises in the LOAD cycle of the last word; wt_done rises the cycle after the
//    last WRITE. Both held in DONE until enable=0, then clear and return to IDLE.
//  - enable is sampled only in IDLE and DONE; deassertion mid-run is ignored.
//  - Addresses hold their last value outside READ/WRITE; wt_data holds last result.
//  - cdf_min/data changing mid-run affect only words captured after the change.
// TESTING
//  1. reset=0 for 2 cycles -> every output 0; release with enable=0 -> stays IDLE, no wt_en.
//  2. cdf_min=1, all A=0x961, all B=0x12C1, enable=1 -> each write data =
//     128'h0000007F_0000007F_0000007F_0000007F (2400*255/4800=127.5 -> 127).
//  3. Swap mid-run: A=0x12C1, B=0x961 -> lanes saturate, data=128'h000000FF x4 from the
//     first word captured after the change; earlier words stay 0x7F.
//  4. Mixed lanes A={1,0x961,0x12C1,0}, B=0x12C1, cdf_min=1 -> lanes {0,0x7F,0xFF,0};
//     B=cdf_min on all lanes -> all-zero result.
//  5. Full run: wt_addr sequence 0x0080..0x00BF, 64 single-cycle wt_en pulses spaced 11
//     cycles, rd_done then wt_done held; enable=0 -> both clear, FSM back to IDLE.
//  6. Assert reset mid-run (word 20) -> outputs 0 at once; restart from k=0 on next enable.

Source files
------------

// File: rtl/divider_top.sv
// divider_top: histogram-equalisation scaling, q = floor((A-cdf_min)*255/(B-cdf_min)) per 32-bit lane
// Ports: clk/reset (async, active-low); enable starts a run; cdf_min is the CDF offset;
//   div_sc_mem_rd_data1/2 are numerator/denominator words (4 lanes each);
//   div_sc_mem_rd_addr1/2, div_sc_mem_wt_addr/wt_data/wt_en drive scratch memory;
//   div_sc_mem_rd_done/wt_done flag run completion and are held until enable drops.
module divider_top #(
    parameter int          NUM_WORDS = 64,
    parameter logic [15:0] RD1_BASE  = 16'h0000,
    parameter logic [15:0] RD2_BASE  = 16'h0040,
    parameter logic [15:0] WT_BASE   = 16'h0080
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  cdf_min,
    input  logic [127:0] div_sc_mem_rd_data1,
    input  logic [127:0] div_sc_mem_rd_data2,
    output logic [127:0] div_sc_mem_wt_data,
    output logic [15:0]  div_sc_mem_rd_addr1,
    output logic [15:0]  div_sc_mem_rd_addr2,
    output logic [15:0]  div_sc_mem_wt_addr,
    output logic         div_sc_mem_wt_en,
    output logic         div_sc_mem_rd_done,
    output logic         div_sc_mem_wt_done
);
    localparam int KW = $clog2(NUM_WORDS);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    logic [2:0]    state;
    logic [KW-1:0] k, k_inc;
    logic [2:0]    cnt;
    logic [39:0]   rem [4];
    logic [39:0]   dsh [4];
    logic [7:0]    quo [4];
    logic [3:0]    sat;
    logic [39:0]   ld_rem [4];
    logic [39:0]   ld_dsh [4];
    logic [39:0]   rem_n [4];
    logic [7:0]    quo_n [4];
    logic [3:0]    ld_sat;
    logic [127:0]  res;
    logic          last;
    assign k_inc = k + KW'(1);
    assign last  = k == KW'(NUM_WORDS - 1);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [31:0] a, b, am, bm;
        logic [39:0] n, d;
        logic        zero, ge;
        assign a  = div_sc_mem_rd_data1[32*i +: 32];
        assign b  = div_sc_mem_rd_data2[32*i +: 32];
        assign am = a - cdf_min;
        assign bm = b - cdf_min;
        assign zero = (a <= cdf_min) || (b <= cdf_min);
        assign n  = 40'(am) * 40'd255;
        // a zero lane divides 0 by 1 so the shared datapath yields q=0
        assign d  = zero ? 40'd1 : {8'd0, bm};
        assign ld_rem[i] = zero ? 40'd0 : n;
        // divisor starts at D<<7 and shifts right once per iteration
        assign ld_dsh[i] = d << 7;
        assign ld_sat[i] = !zero && (n >= (d << 8));
        assign ge = rem[i] >= dsh[i];
        assign rem_n[i] = ge ? rem[i] - dsh[i] : rem[i];
        assign quo_n[i] = {quo[i][6:0], ge};
        assign res[32*i +: 32] = {24'd0, sat[i] ? 8'hFF : quo_n[i]};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            sat <= '0;
            for (int j = 0; j < 4; j++) begin
                rem[j] <= '0;
                dsh[j] <= '0;
                quo[j] <= '0;
            end
            div_sc_mem_wt_data  <= '0;
            div_sc_mem_rd_addr1 <= '0;
            div_sc_mem_rd_addr2 <= '0;
            div_sc_mem_wt_addr  <= '0;
            div_sc_mem_wt_en    <= 1'b0;
            div_sc_mem_rd_done  <= 1'b0;
            div_sc_mem_wt_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= READ;
                    k <= '0;
                    div_sc_mem_rd_addr1 <= RD1_BASE;
                    div_sc_mem_rd_addr2 <= RD2_BASE;
                end
                READ: begin
                    state <= LOAD;
                    if (last) div_sc_mem_rd_done <= 1'b1;
                end
                LOAD: begin
                    state <= DIV;
                    cnt <= '0;
                    sat <= ld_sat;
                    for (int j = 0; j < 4; j++) begin
                        rem[j] <= ld_rem[j];
                        dsh[j] <= ld_dsh[j];
                        quo[j] <= '0;
                    end
                end
                DIV: begin
                    cnt <= cnt + 3'd1;
                    for (int j = 0; j < 4; j++) begin
                        rem[j] <= rem_n[j];
                        dsh[j] <= dsh[j] >> 1;
                        quo[j] <= quo_n[j];
                    end
                    if (cnt == 3'd7) begin
                        state <= WRITE;
                        div_sc_mem_wt_en   <= 1'b1;
                        div_sc_mem_wt_addr <= WT_BASE + 16'(k);
                        div_sc_mem_wt_data <= res;
                    end
                end
                WRITE: begin
                    div_sc_mem_wt_en <= 1'b0;
                    k <= k_inc;
                    if (last) begin
                        state <= DONE;
                        div_sc_mem_wt_done <= 1'b1;
                    end else begin
                        state <= READ;
                        div_sc_mem_rd_addr1 <= RD1_BASE + 16'(k_inc);
                        div_sc_mem_rd_addr2 <= RD2_BASE + 16'(k_inc);
                    end
                end
                DONE: if (!enable) begin
                    state <= IDLE;
                    div_sc_mem_rd_done <= 1'b0;
                    div_sc_mem_wt_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_top.sv
// tb_divider_top: directed checks of divider_top against hand-computed results
module tb_divider_top;
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [31:0]  cdf_min;
    logic [127:0] rd_data1, rd_data2, wt_data;
    logic [15:0]  rd_addr1, rd_addr2, wt_addr;
    logic         wt_en, rd_done, wt_done;
    logic [127:0] mem_a, mem_b;
    int           checks = 0;
    int           failures = 0;
    localparam logic [127:0] Q7F  = 128'h0000007F_0000007F_0000007F_0000007F;
    localparam logic [127:0] QFF  = 128'h000000FF_000000FF_000000FF_000000FF;
    localparam logic [127:0] A961 = 128'h00000961_00000961_00000961_00000961;
    localparam logic [127:0] A12C = 128'h000012C1_000012C1_000012C1_000012C1;
    localparam logic [127:0] ONES = 128'h00000001_00000001_00000001_00000001;
    divider_top dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cdf_min             (cdf_min),
        .div_sc_mem_rd_data1 (rd_data1),
        .div_sc_mem_rd_data2 (rd_data2),
        .div_sc_mem_wt_data  (wt_data),
        .div_sc_mem_rd_addr1 (rd_addr1),
        .div_sc_mem_rd_addr2 (rd_addr2),
        .div_sc_mem_wt_addr  (wt_addr),
        .div_sc_mem_wt_en    (wt_en),
        .div_sc_mem_rd_done  (rd_done),
        .div_sc_mem_wt_done  (wt_done)
    );
    always #5 clk = ~clk;
    // synchronous scratch memory: every word holds the same lane pattern
    always @(posedge clk) begin
        rd_data1 <= mem_a;
        rd_data2 <= mem_b;
    end
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic run(input logic [127:0] exp_lo, input logic [127:0] exp_hi, input int swap_at,
                       input logic [127:0] a2, input logic [127:0] b2);
        int cyc;
        @(negedge clk);
        enable = 1'b1;
        for (int w = 0; w < 64; w++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!wt_en && cyc < 30);
            check("spacing", 128'(cyc), 128'(11));
            check("wt_addr", 128'(wt_addr), 128'(16'h0080 + w));
            check("rd_addr1", 128'(rd_addr1), 128'(w));
            check("rd_addr2", 128'(rd_addr2), 128'(16'h0040 + w));
            check("wt_data", wt_data, w < swap_at ? exp_lo : exp_hi);
            if (w >= 62) check("rd_done_last", 128'(rd_done), 128'(w == 63));
            if (w == swap_at - 1) begin
                mem_a = a2;
                mem_b = b2;
            end
        end
        @(negedge clk);
        check("wt_en_single", 128'(wt_en), 128'(0));
        check("wt_done", 128'(wt_done), 128'(1));
        check("rd_done", 128'(rd_done), 128'(1));
        repeat (3) @(negedge clk);
        check("done_held", 128'({rd_done, wt_done}), 128'(3));
        enable = 1'b0;
        @(negedge clk);
        check("done_clear", 128'({rd_done, wt_done}), 128'(0));
        repeat (12) @(negedge clk);
        check("idle_hold", 128'({wt_en, wt_addr}), 128'(16'h00BF));
    endtask
    initial begin
        #200us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b0;
        enable = 1'b0;
        cdf_min = 32'd1;
        mem_a = A961;
        mem_b = A12C;
        repeat (2) @(negedge clk);
        check("rst_data", wt_data, 128'(0));
        check("rst_addr", 128'({rd_addr1, rd_addr2, wt_addr}), 128'(0));
        check("rst_ctl", 128'({wt_en, rd_done, wt_done}), 128'(0));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_run", 128'({wt_en, rd_done, wt_done, rd_addr1}), 128'(0));
        // 0x7F words, then saturated 0xFF from word 11 after the A/B swap
        run(Q7F, QFF, 11, A12C, A961);
        // mixed lanes
        mem_a = 128'h00000001_00000961_000012C1_00000000;
        mem_b = A12C;
        run(128'h00000000_0000007F_000000FF_00000000, 128'(0), 64, mem_a, mem_b);
        // denominator equal to cdf_min -> zero
        mem_a = A961;
        mem_b = ONES;
        run(128'(0), 128'(0), 64, mem_a, mem_b);
        // reset in the middle of word 20, then restart from word 0
        mem_b = A12C;
        @(negedge clk);
        enable = 1'b1;
        repeat (11 * 20 + 5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_data", wt_data, 128'(0));
        check("mid_rst_addr", 128'({rd_addr1, rd_addr2, wt_addr}), 128'(0));
        check("mid_rst_ctl", 128'({wt_en, rd_done, wt_done}), 128'(0));
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run(Q7F, Q7F, 64, A961, A12C);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
